// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - pipeline-side handshake and result bus of the multiply/divide unit
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hold;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    modport master (
        output start, op, src_a, src_b, hold, flush,
        input  busy, done, div_zero, res_hi, res_lo
    );

    modport slave (
        input  start, op, src_a, src_b, hold, flush,
        output busy, done, div_zero, res_hi, res_lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS-style multiply/divide unit, STEP bits retired per cycle
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 2
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);
    localparam int DW = 2 * WIDTH;
    localparam int XW = WIDTH + STEP;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic accept;
    logic finish;
    logic zero_div;

    // Working state: opnd is |a| for multiply and |b| for divide; work_hi/work_lo
    // form the 2W accumulator (multiply) or remainder/quotient register (divide).
    logic [CW-1:0]    cnt;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic [WIDTH-1:0] res_hi_q;
    logic [WIDTH-1:0] res_lo_q;
    logic             div_zero_q;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [XW-1:0]    mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic [DW-1:0]    prod;
    logic [DW-1:0]    prod_neg;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign bus.busy     = (state == S_BUSY);
    assign bus.done     = (state == S_DONE);
    assign bus.div_zero = div_zero_q;
    assign bus.res_hi   = res_hi_q;
    assign bus.res_lo   = res_lo_q;

    // Operand signs and magnitudes at acceptance; unsigned ops keep raw operands.
    always_comb begin
        sign_a = ~bus.op[0] & bus.src_a[WIDTH-1];
        sign_b = ~bus.op[0] & bus.src_b[WIDTH-1];
        mag_a  = sign_a ? (~bus.src_a + WIDTH'(1)) : bus.src_a;
        mag_b  = sign_b ? (~bus.src_b + WIDTH'(1)) : bus.src_b;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus accept/finish strobes; flush cancels both and forces IDLE.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        zero_div   = 1'b0;
        case (state)
            S_IDLE: begin
                accept = bus.start;
            end
            S_BUSY: begin
                if (cnt == CW'(1)) begin
                    finish     = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.hold) begin
                    accept     = bus.start;
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (accept) begin
            zero_div   = bus.op[1] && (bus.src_b == '0);
            next_state = zero_div ? S_DONE : S_BUSY;
        end
        if (bus.flush) begin
            next_state = S_IDLE;
            accept     = 1'b0;
            finish     = 1'b0;
            zero_div   = 1'b0;
        end
    end

    // One BUSY step of each algorithm; the multiply shifts the accumulator right
    // by STEP so the next multiplier digit always sits in work_lo[STEP-1:0].
    always_comb begin
        mul_sum = {{STEP{1'b0}}, work_hi}
                + ({{STEP{1'b0}}, opnd} * {{WIDTH{1'b0}}, work_lo[STEP-1:0]});
        mul_hi  = mul_sum[XW-1:STEP];
        mul_lo  = {mul_sum[STEP-1:0], work_lo[WIDTH-1:STEP]};
        div_rem = work_hi;
        div_quo = work_lo;
        trial   = '0;
        diff    = '0;
        for (int i = 0; i < STEP; i++) begin
            trial   = {div_rem, div_quo[WIDTH-1]};
            diff    = trial - {1'b0, opnd};
            div_quo = {div_quo[WIDTH-2:0], ~diff[WIDTH]};
            div_rem = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        end
        step_hi = op_div ? div_rem : mul_hi;
        step_lo = op_div ? div_quo : mul_lo;
    end

    // Sign correction applied to the final step's values.
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_neg = ~prod + DW'(1);
        fix_hi   = step_hi;
        fix_lo   = step_lo;
        if (op_div) begin
            if (neg_q) fix_lo = ~step_lo + WIDTH'(1);
            if (neg_r) fix_hi = ~step_hi + WIDTH'(1);
        end else if (neg_q) begin
            fix_hi = prod_neg[DW-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end
    end

    // Datapath: load on accept, iterate in BUSY, publish results only on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            op_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            opnd       <= '0;
            work_hi    <= '0;
            work_lo    <= '0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= CW'(N);
                op_div  <= bus.op[1];
                neg_q   <= sign_a ^ sign_b;
                neg_r   <= sign_a;
                opnd    <= bus.op[1] ? mag_b : mag_a;
                work_hi <= '0;
                work_lo <= bus.op[1] ? mag_a : mag_b;
            end else if (state == S_BUSY && !bus.flush) begin
                cnt     <= cnt - CW'(1);
                work_hi <= step_hi;
                work_lo <= step_lo;
            end
            if (finish) begin
                res_hi_q   <= fix_hi;
                res_lo_q   <= fix_lo;
                div_zero_q <= 1'b0;
            end
            if (zero_div) begin
                res_hi_q   <= bus.src_a;
                res_lo_q   <= '1;
                div_zero_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit at STEP=2 and STEP=1
module tb_muldiv_unit;
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic [7:0]  lat;
    } exp_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last_e[2];
    int   busy_run[2];
    logic prev_done[2];
    logic prev_hold[2];
    logic prev_flush[2];

    muldiv_unit_if #(.WIDTH(32)) bus0 ();
    muldiv_unit_if #(.WIDTH(32)) bus1 ();

    muldiv_unit #(.WIDTH(32), .STEP(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    muldiv_unit #(.WIDTH(32), .STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Reference: plain 64-bit / integer arithmetic following the architectural rules.
    function automatic exp_t model(input int u, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa64;
        longint      sb64;
        logic [63:0] p;
        int          sa;
        int          sb;
        e = '0;
        case (o)
            OP_MULT: begin
                sa64 = longint'($signed(a));
                sb64 = longint'($signed(b));
                p = sa64 * sb64;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1; e.lo = 32'hFFFF_FFFF; e.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'd0;
                end else begin
                    sa = a;
                    sb = b;
                    e.lo = 32'(sa / sb);
                    e.hi = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1; e.lo = 32'hFFFF_FFFF; e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        e.lat = e.dz ? 8'd0 : ((u == 0) ? 8'd16 : 8'd32);
        return e;
    endfunction

    function automatic logic get_busy(input int u);
        return (u == 0) ? bus0.busy : bus1.busy;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Compares every completion against the oldest expected entry, including BUSY length.
    task automatic mon_unit(input int u);
        logic        b, d, h, f, dz;
        logic [31:0] rh, rl;
        exp_t        e;
        int          n;
        if (u == 0) begin
            b = bus0.busy; d = bus0.done; h = bus0.hold; f = bus0.flush;
            dz = bus0.div_zero; rh = bus0.res_hi; rl = bus0.res_lo; n = q0.size();
        end else begin
            b = bus1.busy; d = bus1.done; h = bus1.hold; f = bus1.flush;
            dz = bus1.div_zero; rh = bus1.res_hi; rl = bus1.res_lo; n = q1.size();
        end
        if (rst) begin
            busy_run[u] = 0;
        end else if (b) begin
            busy_run[u]++;
        end else if (d) begin
            if (!prev_done[u] || (!prev_hold[u] && !prev_flush[u])) begin
                if (n == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL u%0d.unexpected_done actual=done required=no_done", u);
                end else begin
                    if (u == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("u%0d.res_hi", u), {32'd0, rh}, {32'd0, e.hi});
                    chk($sformatf("u%0d.res_lo", u), {32'd0, rl}, {32'd0, e.lo});
                    chk($sformatf("u%0d.div_zero", u), {63'd0, dz}, {63'd0, e.dz});
                    chk($sformatf("u%0d.busy_cycles", u), 64'(busy_run[u]), {56'd0, e.lat});
                end
                busy_run[u] = 0;
            end
        end else begin
            busy_run[u] = 0;
        end
        prev_done[u]  = rst ? 1'b0 : d;
        prev_hold[u]  = h;
        prev_flush[u] = f;
    endtask

    always @(negedge clk) begin
        mon_unit(0);
        mon_unit(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one start pulse once the unit is not BUSY; optionally records the expectation.
    task automatic issue(input int u, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        int   t;
        exp_t e;
        t = 0;
        while (get_busy(u)) begin
            cyc();
            t++;
            if (t > 200) begin
                chk($sformatf("u%0d.busy_timeout", u), 64'd1, 64'd0);
                return;
            end
        end
        if (u == 0) begin
            bus0.start = 1'b1; bus0.op = o; bus0.src_a = a; bus0.src_b = b;
        end else begin
            bus1.start = 1'b1; bus1.op = o; bus1.src_a = a; bus1.src_b = b;
        end
        if (push) begin
            e = model(u, o, a, b);
            if (u == 0) q0.push_back(e);
            else        q1.push_back(e);
            last_e[u] = e;
        end
        cyc();
        if (u == 0) begin
            bus0.start = 1'b0; bus0.src_a = $urandom; bus0.src_b = $urandom; bus0.op = 2'($urandom);
        end else begin
            bus1.start = 1'b0; bus1.src_a = $urandom; bus1.src_b = $urandom; bus1.op = 2'($urandom);
        end
    endtask

    task automatic drain(input int u);
        int t;
        t = 0;
        while ((u == 0 ? q0.size() : q1.size()) != 0 || get_busy(u)) begin
            cyc();
            t++;
            if (t > 400) begin
                chk($sformatf("u%0d.drain_timeout", u), 64'd1, 64'd0);
                return;
            end
        end
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus0.start = 1'b0; bus0.op = 2'b00; bus0.src_a = '0; bus0.src_b = '0;
        bus0.hold = 1'b0; bus0.flush = 1'b0;
        bus1.start = 1'b0; bus1.op = 2'b00; bus1.src_a = '0; bus1.src_b = '0;
        bus1.hold = 1'b0; bus1.flush = 1'b0;
        last_e[0] = '0;
        last_e[1] = '0;
        rst = 1'b1;
        repeat (3) cyc();
        chk("reset.busy", {63'd0, bus0.busy}, 64'd0);
        chk("reset.done", {63'd0, bus0.done}, 64'd0);
        chk("reset.div_zero", {63'd0, bus0.div_zero}, 64'd0);
        chk("reset.res_hi", {32'd0, bus0.res_hi}, 64'd0);
        chk("reset.res_lo", {32'd0, bus0.res_lo}, 64'd0);
        rst = 1'b0;
        cyc();

        // Directed arithmetic corners, issued back-to-back.
        issue(0, OP_MULT, 32'hFFFF_FFFD, 32'd5, 1);
        issue(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1);
        issue(0, OP_DIVU, 32'd7, 32'd2, 1);
        issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(0, OP_DIVU, 32'h0000_1234, 32'd0, 1);
        issue(0, OP_MULTU, 32'd2, 32'd3, 1);
        issue(0, OP_DIV, 32'h8765_4321, 32'd0, 1);
        issue(0, OP_DIVU, 32'd5, 32'd0, 1);
        issue(0, OP_DIV, 32'd7, 32'hFFFF_FFFE, 1);
        drain(0);

        // Flush on the fifth BUSY cycle: no completion, results untouched.
        issue(0, OP_MULT, 32'h1234_5678, 32'h0000_0F0F, 0);
        repeat (4) cyc();
        bus0.flush = 1'b1;
        bus0.start = 1'b1;
        cyc();
        bus0.flush = 1'b0;
        bus0.start = 1'b0;
        chk("flush.busy", {63'd0, bus0.busy}, 64'd0);
        chk("flush.done", {63'd0, bus0.done}, 64'd0);
        repeat (20) cyc();
        chk("flush.res_hi", {32'd0, bus0.res_hi}, {32'd0, last_e[0].hi});
        chk("flush.res_lo", {32'd0, bus0.res_lo}, {32'd0, last_e[0].lo});
        chk("flush.div_zero", {63'd0, bus0.div_zero}, {63'd0, last_e[0].dz});

        // Reset in the middle of BUSY clears everything.
        issue(0, OP_MULTU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_busy.busy", {63'd0, bus0.busy}, 64'd0);
        chk("rst_busy.done", {63'd0, bus0.done}, 64'd0);
        chk("rst_busy.res_hi", {32'd0, bus0.res_hi}, 64'd0);
        chk("rst_busy.res_lo", {32'd0, bus0.res_lo}, 64'd0);
        last_e[0] = '0;
        repeat (20) cyc();
        chk("rst_busy.no_done", {63'd0, bus0.done}, 64'd0);

        // Hold in DONE: result stable, start ignored; release together with a new start.
        bus0.hold = 1'b1;
        issue(0, OP_DIVU, 32'd100, 32'd7, 1);
        t = 0;
        while (!bus0.done && t < 100) begin
            cyc();
            t++;
        end
        for (int k = 0; k < 3; k++) begin
            chk("hold.done", {63'd0, bus0.done}, 64'd1);
            chk("hold.res_lo", {32'd0, bus0.res_lo}, 64'd14);
            chk("hold.res_hi", {32'd0, bus0.res_hi}, 64'd2);
            if (k == 1) begin
                bus0.start = 1'b1; bus0.op = OP_MULTU; bus0.src_a = 32'd5; bus0.src_b = 32'd5;
            end
            cyc();
            bus0.start = 1'b0;
        end
        bus0.hold = 1'b0;
        issue(0, OP_DIVU, 32'd9, 32'd4, 1);
        drain(0);

        // Randomised traffic with mixed back-to-back and idle-gap acceptance.
        for (int i = 0; i < 40; i++) begin
            issue(0, 2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1);
            repeat ($urandom_range(0, 2)) cyc();
        end
        drain(0);

        // Single-bit-per-cycle instance.
        issue(1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(1, OP_MULT, 32'hFFFF_FFFD, 32'd5, 1);
        issue(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(1, OP_DIVU, 32'h0000_1234, 32'd0, 1);
        for (int i = 0; i < 15; i++) begin
            issue(1, 2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1);
            repeat ($urandom_range(0, 1)) cyc();
        end
        drain(1);

        chk("u0.pending_at_end", 64'(q0.size()), 64'd0);
        chk("u1.pending_at_end", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the EX stage.
- Computes MIPS-style 2W-bit products, and quotient/remainder pairs returned as {hi, lo}.
- Retires STEP bits per cycle with a fixed, deterministic latency.
- Adds an explicit start/busy/done handshake, pipeline hold, flush and a defined divide-by-zero result.
- The HI/LO architectural registers stay outside this block; the pipeline writes them from res_hi/res_lo.

Parameters:
WIDTH, 32, operand width W in bits.
STEP, 2, bits retired per BUSY cycle (1, 2, 4 or 8); must divide WIDTH.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  request a new operation; sampled only in IDLE, or in DONE when hold=0
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
src_a  input  WIDTH  multiplicand / dividend
src_b  input  WIDTH  multiplier / divisor
hold  input  1  downstream stall; keeps the block in DONE
flush  input  1  abort (exception/redirect)
busy  output  1  high in BUSY; the pipeline stalls on busy|(start&idle)
done  output  1  high in DONE (result valid)
div_zero  output  1  last completed op was a divide with src_b=0
res_hi  output  WIDTH  mul: product[2W-1:W]; div: remainder
res_lo  output  WIDTH  mul: product[W-1:0]; div: quotient

Behaviour:
- Clock is clk; reset rst is synchronous, active-high.
- Reset:
  - state IDLE; busy=0, done=0, div_zero=0, res_hi=0, res_lo=0.
  - Reset overrides any in-flight operation; nothing completes.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 latches op, the operand magnitudes, and the result signs (signed ops only).
  - Quotient/product sign = a[W-1]^b[W-1]; remainder sign = a[W-1].
  - Iteration counter loads N=WIDTH/STEP; next state BUSY.
  - Exception: a divide with src_b=0 goes directly to DONE.
- BUSY:
  - Per cycle, multiply adds |a| * (next STEP bits of |b|, LSB first) into the 2W accumulator at the correct shift.
  - Per cycle, divide performs STEP chained restoring-division iterations on a 2W remainder/quotient register.
  - Counter decrements; when the counter reaches 1, the next state is DONE.
  - The final cycle applies two's-complement sign correction and registers res_hi/res_lo/div_zero.
  - No early termination: latency is always exactly N BUSY cycles.
- Latency: start sampled at edge T -> busy=1 on cycles T+1..T+N -> done=1 from T+N+1.
- DONE:
  - Results stay valid.
  - With hold=1, remain in DONE; start is ignored.
  - With hold=0, leave next edge: start=1 in that cycle begins a new op (back-to-back, same as IDLE acceptance, including the src_b=0 shortcut to DONE); otherwise go to IDLE.
- start while BUSY is ignored.
- flush:
  - Any state -> IDLE at the next edge; highest priority after rst.
  - A concurrent start is ignored.
  - res_hi/res_lo/div_zero keep their last completed values; a flushed op never writes them.
- res_hi/res_lo hold the last completed result until the next completion; they change only on the edge entering DONE.
- Divide by zero:
  - res_lo = all ones, res_hi = src_a (raw), div_zero=1, done one cycle after start.
  - Sign fix-up is not applied.
  - div_zero clears on the next completed op.
- Signed overflow MIN/-1 (DIV): res_lo = MIN (0x80000000 at W=32), res_hi = 0, no flag.
- Arithmetic rules:
  - Unsigned ops use raw operands.
  - Signed ops use magnitudes (|MIN| = 2^(W-1) as unsigned) followed by negation.
  - Remainder magnitude < |divisor|; the truncating-division identity a = q*b + r holds in W-bit two's complement.
- src_a/src_b/op need not be held after the start cycle.

Test Plan:
- MULT -3 x 5 (W=32, STEP=2) -> busy exactly 16 cycles; done with res_hi=FFFFFFFF, res_lo=FFFFFFF1.
- MULTU FFFFFFFF x FFFFFFFF -> res_hi=FFFFFFFE, res_lo=00000001; repeat at STEP=1 -> same result, 32 busy cycles.
- DIV -7 / 2 -> res_lo=FFFFFFFD, res_hi=FFFFFFFF; DIVU 7 / 2 -> res_lo=3, res_hi=1; DIV 80000000 / FFFFFFFF -> res_lo=80000000, res_hi=0.
- DIVU 1234 / 0 -> done on the next cycle, div_zero=1, res_lo=FFFFFFFF, res_hi=00001234; the following MULTU 2x3 clears div_zero (res_lo=6).
- MULT started, flush on busy cycle 5 -> IDLE next cycle, done never asserts, res_* keep the prior values; rst mid-BUSY -> all outputs 0.
- done with hold=1 for 3 cycles -> result stable, a start pulse is ignored; drop hold with start=1 (DIVU 9/4) -> new op accepted that edge, res_lo=2, res_hi=1 after N busy cycles.
